// File: rtl/cpu_core_mc.sv
// rtl/cpu_core_mc.sv - multi-cycle CPU core with fetch/data req-ready ports
// CPU_ILL_TRAP_EN: illegal opcodes halt the core instead of executing as NOP.
module cpu_core_mc #(
   parameter int DATA_W = 19,
   parameter int OPC_W  = 6,
   parameter int RA_W   = 5,
   parameter int IMM_W  = 3,
   parameter int PC_W   = 19
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req,
   output logic [PC_W-1:0]   imem_addr,
   input  logic              imem_ready,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ready,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic [PC_W-1:0]   pcout,
   output logic [DATA_W-1:0] aluout,
   output logic [7:0]        flags,
   output logic              halted
);
   typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

   localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(1);
   localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(2);
   localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(3);
   localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(4);
   localparam logic [OPC_W-1:0] OP_XOR  = OPC_W'(5);
   localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(6);
   localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(7);
   localparam logic [OPC_W-1:0] OP_ST   = OPC_W'(8);
   localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(9);
   localparam logic [OPC_W-1:0] OP_JMP  = OPC_W'(10);
   localparam logic [OPC_W-1:0] OP_HALT = '1;
   localparam logic [PC_W-1:0]  PC_ONE  = PC_W'(1);

   state_t                r_state;
   logic [PC_W-1:0]       r_pc, r_next_pc;
   logic [DATA_W-1:0]     r_instr, r_aluout, r_mdr, r_dmem_wdata;
   logic [DATA_W-1:0]     r_regs [2**RA_W];
   logic [3:0]            r_flags;
   logic                  r_ill, r_imem_req, r_dmem_req, r_dmem_we, r_wr_en, r_is_ld;

   logic [OPC_W-1:0]      w_opc;
   logic [RA_W-1:0]       w_rd, w_rs;
   logic [IMM_W-1:0]      w_imm;
   logic [DATA_W-1:0]     w_rd_val, w_rs_val, w_imm_z, w_b, w_res, w_ea;
   logic [DATA_W:0]       w_sum;
   logic [PC_W-1:0]       w_imm_s, w_pc_inc, w_br_tgt;
   logic                  w_c, w_v, w_alu_op, w_illegal;

   assign w_opc    = r_instr[DATA_W-1 -: OPC_W];
   assign w_rd     = r_instr[DATA_W-1-OPC_W -: RA_W];
   assign w_rs     = r_instr[DATA_W-1-OPC_W-RA_W -: RA_W];
   assign w_imm    = r_instr[IMM_W-1:0];
   assign w_rd_val = r_regs[w_rd];
   assign w_rs_val = r_regs[w_rs];
   assign w_imm_z  = {{(DATA_W-IMM_W){1'b0}}, w_imm};
   assign w_imm_s  = {{(PC_W-IMM_W){w_imm[IMM_W-1]}}, w_imm};
   assign w_b      = (w_opc == OP_ADDI) ? w_imm_z : w_rs_val;
   assign w_ea     = w_rs_val + w_imm_z;
   assign w_pc_inc = r_pc + PC_ONE;
   assign w_br_tgt = w_pc_inc + w_imm_s;
   assign w_illegal = (w_opc > OP_JMP) && (w_opc != OP_HALT);

   // Carry/borrow come from the extra sum bit; V compares operand and result signs.
   always_comb begin
      w_sum    = '0;
      w_res    = '0;
      w_c      = 1'b0;
      w_v      = 1'b0;
      w_alu_op = 1'b1;
      case (w_opc)
         OP_ADD, OP_ADDI: begin
            w_sum = {1'b0, w_rd_val} + {1'b0, w_b};
            w_res = w_sum[DATA_W-1:0];
            w_c   = w_sum[DATA_W];
            w_v   = (w_rd_val[DATA_W-1] == w_b[DATA_W-1]) && (w_res[DATA_W-1] != w_rd_val[DATA_W-1]);
         end
         OP_SUB: begin
            w_sum = {1'b0, w_rd_val} - {1'b0, w_rs_val};
            w_res = w_sum[DATA_W-1:0];
            w_c   = w_sum[DATA_W];
            w_v   = (w_rd_val[DATA_W-1] != w_rs_val[DATA_W-1]) && (w_res[DATA_W-1] != w_rd_val[DATA_W-1]);
         end
         OP_AND:  w_res = w_rd_val & w_rs_val;
         OP_OR:   w_res = w_rd_val | w_rs_val;
         OP_XOR:  w_res = w_rd_val ^ w_rs_val;
         default: w_alu_op = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_FETCH;
         r_pc         <= '0;
         r_next_pc    <= '0;
         r_instr      <= '0;
         r_aluout     <= '0;
         r_mdr        <= '0;
         r_dmem_wdata <= '0;
         r_flags      <= '0;
         r_ill        <= 1'b0;
         r_imem_req   <= 1'b0;
         r_dmem_req   <= 1'b0;
         r_dmem_we    <= 1'b0;
         r_wr_en      <= 1'b0;
         r_is_ld      <= 1'b0;
         for (int i = 0; i < 2**RA_W; i++) r_regs[i] <= '0;
      end else begin
         case (r_state)
            S_FETCH: begin
               if (!r_imem_req) begin
                  r_imem_req <= 1'b1;
               end else if (imem_ready) begin
                  r_instr    <= imem_rdata;
                  r_imem_req <= 1'b0;
                  r_state    <= S_EXEC;
               end
            end
            S_EXEC: begin
               r_next_pc <= w_pc_inc;
               r_wr_en   <= w_alu_op;
               r_is_ld   <= (w_opc == OP_LD);
               if (w_alu_op) begin
                  r_aluout <= w_res;
                  r_flags  <= {w_v, w_c, w_res[DATA_W-1], (w_res == '0)};
               end
               case (w_opc)
                  OP_LD, OP_ST: begin
                     r_aluout     <= w_ea;
                     r_dmem_req   <= 1'b1;
                     r_dmem_we    <= (w_opc == OP_ST);
                     r_dmem_wdata <= w_rd_val;
                     r_state      <= S_MEM;
                  end
                  OP_BEQ: begin
                     r_next_pc <= (w_rd_val == w_rs_val) ? w_br_tgt : w_pc_inc;
                     r_state   <= S_WB;
                  end
                  OP_JMP: begin
                     r_next_pc <= w_rs_val[PC_W-1:0];
                     r_state   <= S_WB;
                  end
                  OP_HALT: r_state <= S_HALT;
                  default: begin
                     r_ill <= r_ill | w_illegal;
`ifdef CPU_ILL_TRAP_EN
                     r_state <= w_illegal ? S_HALT : S_WB;
`else
                     r_state <= S_WB;
`endif
                  end
               endcase
            end
            S_MEM: begin
               if (dmem_ready) begin
                  r_dmem_req <= 1'b0;
                  r_dmem_we  <= 1'b0;
                  if (r_dmem_we) begin
                     r_pc       <= r_next_pc;
                     r_imem_req <= 1'b1;
                     r_state    <= S_FETCH;
                  end else begin
                     r_mdr   <= dmem_rdata;
                     r_state <= S_WB;
                  end
               end
            end
            S_WB: begin
               if (r_wr_en || r_is_ld) r_regs[w_rd] <= r_is_ld ? r_mdr : r_aluout;
               r_pc       <= r_next_pc;
               r_imem_req <= 1'b1;
               r_state    <= S_FETCH;
            end
            S_HALT:  r_state <= S_HALT;
            default: r_state <= S_FETCH;
         endcase
      end
   end

   assign imem_req   = r_imem_req;
   assign imem_addr  = r_pc;
   assign dmem_req   = r_dmem_req;
   assign dmem_we    = r_dmem_we;
   assign dmem_addr  = r_aluout;
   assign dmem_wdata = r_dmem_wdata;
   assign pcout      = r_pc;
   assign aluout     = r_aluout;
   assign flags      = {r_ill, 3'b000, r_flags};
   assign halted     = (r_state == S_HALT);
endmodule

// File: tb/tb_cpu_core_mc.sv
// tb/tb_cpu_core_mc.sv - scoreboard bench for cpu_core_mc
module tb_cpu_core_mc;
   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, halted;
   logic [18:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, pcout, aluout;
   logic [7:0]  flags;

   cpu_core_mc dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
      .pcout(pcout), .aluout(aluout), .flags(flags), .halted(halted)
   );

   always #5 clk = ~clk;

   typedef struct {logic [18:0] pc; logic [18:0] alu; logic [7:0] fl; int cyc; logic halt;} exp_t;
   typedef struct {logic [18:0] addr; logic [18:0] data;} st_t;

   exp_t        exp_q[$];
   st_t         st_q[$];
   logic [18:0] dmem_arr [0:255];
   int          n_cmp = 0, n_bad = 0, dwait = 0, stable_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [18:0] ins(input int opc, input int rd, input int rs, input int imm);
      return {opc[5:0], rd[4:0], rs[4:0], imm[2:0]};
   endfunction

   task automatic wait_ireq();
      int n = 0;
      while (!imem_req && n < 20) begin @(negedge clk); n++; end
      check("ireq_seen", imem_req, 1);
   endtask

   task automatic step(input logic [18:0] instr, input logic [18:0] fpc, input int iw, input int dw,
                       input logic [18:0] npc, input logic [18:0] alu, input logic [7:0] fl,
                       input int cyc, input logic halt);
      exp_t e;
      int   n = 0;
      dwait = dw;
      wait_ireq();
      check("faddr", imem_addr, fpc);
      exp_q.push_back('{npc, alu, fl, cyc, halt});
      repeat (iw) begin @(negedge clk); n++; end
      if (iw > 0) check("fstable", {imem_req, imem_addr}, {1'b1, fpc});
      imem_ready = 1'b1;
      imem_rdata = instr;
      @(negedge clk); n++;
      imem_ready = 1'b0;
      imem_rdata = '0;
      check("ireq_drop", imem_req, 0);
      while (!imem_req && !halted && n < 60) begin @(negedge clk); n++; end
      e = exp_q.pop_front();
      check("cycles", n, e.cyc);
      check("pc", pcout, e.pc);
      check("alu", aluout, e.alu);
      check("flags", flags, e.fl);
      check("halted", halted, e.halt);
   endtask

   // Data memory responder: holds ready low for dwait cycles, checks payload stability.
   initial begin
      logic [18:0] a, wd;
      logic        we, ab;
      st_t         s;
      for (int i = 0; i < 256; i++) dmem_arr[i] = '0;
      dmem_ready = 1'b0;
      dmem_rdata = '0;
      forever begin
         @(negedge clk);
         if (dmem_req && reset) begin
            a = dmem_addr; we = dmem_we; wd = dmem_wdata; ab = 1'b0;
            for (int w = 0; w < dwait; w++) begin
               @(negedge clk);
               if (!reset) begin ab = 1'b1; break; end
               if (!dmem_req || dmem_addr != a || dmem_we != we || dmem_wdata != wd) stable_err++;
            end
            if (!ab) begin
               dmem_ready = 1'b1;
               dmem_rdata = dmem_arr[a[7:0]];
               if (we) begin
                  if (st_q.size() == 0) check("st_unexpected", we, 0);
                  else begin
                     s = st_q.pop_front();
                     check("st_addr", a, s.addr);
                     check("st_data", wd, s.data);
                  end
                  dmem_arr[a[7:0]] = wd;
               end
               @(negedge clk);
               dmem_ready = 1'b0;
               dmem_rdata = '0;
               check("dreq_drop", dmem_req, 0);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset = 1'b0; imem_ready = 1'b0; imem_rdata = '0;
      repeat (3) @(negedge clk);
      check("rst_pc", pcout, 0);
      check("rst_alu", aluout, 0);
      check("rst_flags", flags, 0);
      check("rst_reqs", {imem_req, dmem_req, dmem_we, halted}, 0);
      #2 reset = 1'b1;

      step(ins(6,1,0,5),   0, 0,0,  1,     5, 8'h00, 3, 0);
      step(ins(6,2,0,3),   1, 0,0,  2,     3, 8'h00, 3, 0);
      step(ins(2,1,2,0),   2, 0,0,  3,     2, 8'h00, 3, 0);
      st_q.push_back('{19'd0, 19'd2});
      step(ins(8,1,0,0),   3, 0,0,  4,     0, 8'h00, 3, 0);
      step(ins(5,2,2,0),   4, 0,0,  5,     0, 8'h01, 3, 0);
      step(ins(6,2,0,1),   5, 0,0,  6,     1, 8'h00, 3, 0);
      step(ins(5,1,1,0),   6, 0,0,  7,     0, 8'h01, 3, 0);
      step(ins(2,1,2,0),   7, 0,0,  8, 19'h7FFFF, 8'h06, 3, 0);
      step(ins(1,1,2,0),   8, 0,0,  9,     0, 8'h05, 3, 0);
      step(ins(5,1,1,0),   9, 0,0, 10,     0, 8'h01, 3, 0);
      step(ins(9,1,0,4),  10, 0,0,  7,     0, 8'h01, 3, 0);
      step(ins(9,1,2,4),   7, 0,0,  8,     0, 8'h01, 3, 0);
      step(ins(6,3,0,7),   8, 0,0,  9,     7, 8'h00, 3, 0);
      step(ins(6,4,0,3),   9, 0,0, 10,     3, 8'h00, 3, 0);
      st_q.push_back('{19'd5, 19'd7});
      step(ins(8,3,4,2),  10, 4,4, 11,     5, 8'h00, 11, 0);
      step(ins(7,5,4,2),  11, 4,4, 12,     5, 8'h00, 12, 0);
      st_q.push_back('{19'd1, 19'd7});
      step(ins(8,5,0,1),  12, 0,0, 13,     1, 8'h00, 3, 0);
      step(ins(2,6,2,0),  13, 0,0, 14, 19'h7FFFF, 8'h06, 3, 0);
      step(ins(10,0,6,0), 14, 0,0, 19'h7FFFF, 19'h7FFFF, 8'h06, 3, 0);
      step(ins(0,0,0,0), 19'h7FFFF, 0,0, 0, 19'h7FFFF, 8'h06, 3, 0);
`ifdef CPU_ILL_TRAP_EN
      step(ins(32,0,0,0),  0, 0,0,  0, 19'h7FFFF, 8'h86, 2, 1);
`else
      step(ins(32,0,0,0),  0, 0,0,  1, 19'h7FFFF, 8'h86, 3, 0);
      step(ins(63,0,0,0),  1, 0,0,  1, 19'h7FFFF, 8'h86, 2, 1);
`endif
      repeat (3) @(negedge clk);
      check("halt_hold", {halted, imem_req}, 2'b10);

      #2 reset = 1'b0;
      #1 check("rst2_state", {pcout, aluout, flags, imem_req, halted}, 0);
      @(negedge clk);
      #2 reset = 1'b1;

      // Abandon a load mid-MEM with an asynchronous reset.
      dwait = 50;
      wait_ireq();
      check("rfaddr", imem_addr, 0);
      imem_ready = 1'b1;
      imem_rdata = ins(7,1,0,5);
      @(negedge clk);
      imem_ready = 1'b0;
      imem_rdata = '0;
      n = 0;
      while (!dmem_req && n < 10) begin @(negedge clk); n++; end
      check("rdreq", dmem_req, 1);
      check("rdaddr", dmem_addr, 5);
      #2 reset = 1'b0;
      #1 check("rst_dreq", dmem_req, 0);
      check("rst_pc2", pcout, 0);
      @(negedge clk);
      #2 reset = 1'b1;

      st_q.push_back('{19'd6, 19'd0});
      step(ins(8,3,0,6),   0, 0,0,  1,     6, 8'h00, 3, 0);
      step(ins(63,0,0,0),  1, 0,0,  1,     6, 8'h00, 2, 1);
      check("dstable", stable_err, 0);
      check("st_q_empty", st_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
